// File: rtl/inv_req_sched.sv
// inv_req_sched
//   Request scheduler in front of the iterative Montgomery-domain inverter.
//   Tagged operands are queued in a small FIFO. One inversion runs at a time:
//   the head is popped, the inverter is started with a one-cycle pulse, and
//   the scheduler waits for busy to drop. The result and tag are then held on
//   a valid/ready output. Zero operands skip the inverter and return an error,
//   and a watchdog aborts a run that stays busy for too long.
//
//   Ports
//     clk, rstn              clock, asynchronous active-low reset
//     in_valid/in_ready      operand request handshake (in_ready = FIFO not full)
//     in_data, in_tag        operand (Montgomery form) and request tag
//     n_in                   modulus, quasi-static, passed straight to inv_n
//     out_valid/out_ready    result handshake
//     out_data, out_tag      inverse (0 on error) and tag of the completed request
//     out_err                1 = zero operand or watchdog abort
//     inv_start, inv_wdata   inverter start pulse and operand
//     inv_n                  inverter modulus
//     inv_rdata, inv_busy    inverter result and busy flag
//     fifo_level             number of queued requests
//
//   state  | meaning
//   IDLE   | waiting for a queued request, output slot empty
//   LAUNCH | inv_start pulse, operand on inv_wdata
//   WAIT   | inverter running, watchdog counting
//   ERR    | zero operand, return error without starting the inverter
//   OUT    | result presented until the downstream accepts it
module inv_req_sched #(
    parameter int W       = 257,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int MAX_CYC = 1100
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [W-1:0]             n_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err,
    output logic                     inv_start,
    output logic [W-1:0]             inv_wdata,
    output logic [W-1:0]             inv_n,
    input  logic [W-1:0]             inv_rdata,
    input  logic                     inv_busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(MAX_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYC - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_ERR    = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    logic [TAG_W+W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;

    state_t             state_q, state_d;
    logic               inv_start_q, inv_start_d;
    logic [W-1:0]       inv_wdata_q, inv_wdata_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               out_err_q, out_err_d;

    logic               push;
    logic               pop;
    logic [TAG_W+W-1:0] head;
    logic [W-1:0]       head_data;
    logic [TAG_W-1:0]   head_tag;

    assign in_ready   = (level_q != LVL_FULL);
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == S_IDLE) && (level_q != '0) && !out_valid_q;
    assign head       = mem_q[rd_ptr_q];
    assign head_data  = head[W-1:0];
    assign head_tag   = head[TAG_W+W-1:W];

    assign fifo_level = level_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_tag    = out_tag_q;
    assign out_err    = out_err_q;
    assign inv_start  = inv_start_q;
    assign inv_wdata  = inv_wdata_q;
    assign inv_n      = n_in;

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_tag, in_data};
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        inv_start_d = 1'b0;
        inv_wdata_d = inv_wdata_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_err_d   = out_err_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    inv_wdata_d = head_data;
                    out_tag_d   = head_tag;
                    if (head_data == '0) begin
                        state_d = S_ERR;
                    end else begin
                        // Registered pulse: high for exactly the LAUNCH cycle.
                        inv_start_d = 1'b1;
                        state_d     = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // busy in the first WAIT cycle still reflects the pre-start
                // inverter, so completion is only trusted from cnt != 0.
                if ((cnt_q != '0) && !inv_busy) begin
                    out_data_d  = inv_rdata;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else if (cnt_q == CNT_LAST) begin
                    out_data_d  = '0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ERR: begin
                out_data_d  = '0;
                out_err_d   = 1'b1;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= S_IDLE;
            inv_start_q <= 1'b0;
            inv_wdata_q <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            inv_start_q <= inv_start_d;
            inv_wdata_q <= inv_wdata_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule
